cheri_tbre_sweep: RTL and testbench

// Background revocation sweep engine; drives the TBRE side of cheri_trvk_stage.
// - Walks a memory range one 8-byte capability slot at a time and issues TBRE loads via the LSU.
// - Consumes the revocation verdict (tbre_trvk_en/clrtag) produced 3 cycles after each TBRE load response.
// - Writes the slot back with its tag cleared when the capability is revoked.

---
 rtl/cheri_tbre_sweep.sv | 226 ++++++++++++++++++++++
 tb/tb_cheri_tbre_sweep.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cheri_tbre_sweep.sv
// Background revocation sweep: walks a range of 8-byte capability slots, loads each one,
// waits for the revocation verdict and writes revoked slots back with the tag cleared.

package cheri_tbre_sweep_pkg;

    typedef struct packed {
        logic        valid;
        logic [1:0]  top_cor;
        logic [1:0]  base_cor;
        logic [4:0]  cexp;
        logic [8:0]  top;
        logic [8:0]  base;
        logic [3:0]  otype;
        logic [12:0] cperms;
    } reg_cap_t;

    localparam reg_cap_t NULL_REG_CAP = '{
        valid:    1'b0,
        top_cor:  2'd0,
        base_cor: 2'd0,
        cexp:     5'd24,
        top:      9'h100,
        base:     9'h000,
        otype:    4'd0,
        cperms:   13'd0
    };

endpackage

module cheri_tbre_sweep
    import cheri_tbre_sweep_pkg::*;
#(
    parameter int unsigned TrvkTimeout = 16,
    parameter int unsigned CntWidth    = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                start_i,
    input  logic                stop_i,
    input  logic [31:0]         start_addr_i,
    input  logic [31:0]         end_addr_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [CntWidth-1:0] revoked_cnt_o,

    output logic                tbre_lsu_req_o,
    output logic                tbre_lsu_we_o,
    output logic [31:0]         tbre_lsu_addr_o,
    output logic [31:0]         tbre_lsu_wdata_o,
    output reg_cap_t            tbre_lsu_wcap_o,
    input  logic                lsu_tbre_req_done_i,
    input  logic                lsu_tbre_resp_valid_i,
    input  logic                lsu_tbre_resp_err_i,
    input  logic [31:0]         rf_wdata_lsu_i,
    input  reg_cap_t            rf_wcap_lsu_i,

    input  logic                tbre_trvk_en_i,
    input  logic                tbre_trvk_clrtag_i
);

    // LSU handshake: a request is offered while tbre_lsu_req_o=1 with we/addr/wdata/wcap held
    // stable; it is accepted in the cycle lsu_tbre_req_done_i=1, and its single response is
    // the later cycle with lsu_tbre_resp_valid_i=1. Only one request is ever outstanding.

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        CHECK      = 4'd1,
        LOAD_REQ   = 4'd2,
        LOAD_WAIT  = 4'd3,
        TRVK_WAIT  = 4'd4,
        STORE_REQ  = 4'd5,
        STORE_WAIT = 4'd6,
        NEXT       = 4'd7,
        DONE       = 4'd8
    } state_e;

    localparam logic [4:0] TimerLast = 5'(TrvkTimeout - 1);

    state_e                state_q, state_d;
    logic [31:0]           addr_q;
    logic [31:0]           end_q;
    logic                  stop_q;
    logic                  err_q;
    logic [CntWidth-1:0]   cnt_q;
    logic [31:0]           data_q;
    reg_cap_t              cap_q;
    logic                  lerr_q;
    logic [4:0]            timer_q;

    logic [32:0]           addr_inc;
    logic                  revoke;
    logic                  trvk_expired;

    assign addr_inc     = {1'b0, addr_q} + 33'd8;
    assign revoke       = tbre_trvk_clrtag_i && !lerr_q && cap_q.valid;
    assign trvk_expired = !tbre_trvk_en_i && (timer_q == TimerLast);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (start_i) state_d = CHECK;
            CHECK:      state_d = (addr_q >= end_q) ? DONE : LOAD_REQ;
            LOAD_REQ:   if (lsu_tbre_req_done_i) state_d = LOAD_WAIT;
            LOAD_WAIT:  if (lsu_tbre_resp_valid_i) state_d = TRVK_WAIT;
            TRVK_WAIT: begin
                if (tbre_trvk_en_i) begin
                    state_d = revoke ? STORE_REQ : NEXT;
                end else if (trvk_expired) begin
                    state_d = NEXT;
                end
            end
            STORE_REQ:  if (lsu_tbre_req_done_i) state_d = STORE_WAIT;
            STORE_WAIT: if (lsu_tbre_resp_valid_i) state_d = NEXT;
            NEXT:       state_d = (addr_inc[32] || stop_q || stop_i) ? DONE : CHECK;
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy_o         = 1'b1;
        done_o         = 1'b0;
        tbre_lsu_req_o = 1'b0;
        tbre_lsu_we_o  = 1'b0;
        unique case (state_q)
            IDLE:      busy_o = 1'b0;
            DONE: begin
                busy_o = 1'b0;
                done_o = 1'b1;
            end
            LOAD_REQ:  tbre_lsu_req_o = 1'b1;
            STORE_REQ: begin
                tbre_lsu_req_o = 1'b1;
                tbre_lsu_we_o  = 1'b1;
            end
            default: ;
        endcase
    end

    // Sweep datapath: range, captured slot contents, sticky status
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            end_q   <= '0;
            stop_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
            cap_q   <= NULL_REG_CAP;
            lerr_q  <= 1'b0;
            timer_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        addr_q <= start_addr_i & ~32'h7;
                        end_q  <= end_addr_i & ~32'h7;
                        err_q  <= 1'b0;
                        cnt_q  <= '0;
                        stop_q <= 1'b0;
                    end
                end
                LOAD_WAIT: begin
                    if (lsu_tbre_resp_valid_i) begin
                        data_q <= rf_wdata_lsu_i;
                        cap_q  <= rf_wcap_lsu_i;
                        lerr_q <= lsu_tbre_resp_err_i;
                        if (lsu_tbre_resp_err_i) err_q <= 1'b1;
                    end
                end
                TRVK_WAIT: begin
                    if (trvk_expired) err_q <= 1'b1;
                end
                STORE_WAIT: begin
                    if (lsu_tbre_resp_valid_i) begin
                        if (lsu_tbre_resp_err_i) begin
                            err_q <= 1'b1;
                        end else if (cnt_q != '1) begin
                            cnt_q <= cnt_q + CntWidth'(1);
                        end
                    end
                end
                NEXT:    addr_q <= addr_inc[31:0];
                default: ;
            endcase

            // A stop seen at any point of a busy sweep waits for the next slot boundary.
            if (state_q != IDLE && state_q != DONE && stop_i) begin
                stop_q <= 1'b1;
            end

            timer_q <= (state_q == TRVK_WAIT) ? timer_q + 5'd1 : 5'd0;
        end
    end

    assign err_o            = err_q;
    assign revoked_cnt_o    = cnt_q;
    assign tbre_lsu_addr_o  = addr_q;
    assign tbre_lsu_wdata_o = data_q;

    always_comb begin
        tbre_lsu_wcap_o       = cap_q;
        tbre_lsu_wcap_o.valid = 1'b0;
    end

    req_stable_a: assert property (@(posedge clk_i) disable iff (rst_i)
        (tbre_lsu_req_o && !lsu_tbre_req_done_i) |=>
            (tbre_lsu_req_o && $stable(tbre_lsu_we_o) && $stable(tbre_lsu_addr_o)));

    addr_aligned_a: assert property (@(posedge clk_i) disable iff (rst_i)
        tbre_lsu_addr_o[2:0] == 3'b000);

endmodule

// File: tb/tb_cheri_tbre_sweep.sv
// Bench for cheri_tbre_sweep: a reactive LSU/verdict responder, a slot-level reference model
// feeding an expected request queue, a directed vector table and randomized sweeps.
`timescale 1ns/1ps

module tb_cheri_tbre_sweep;
    import cheri_tbre_sweep_pkg::*;

    localparam int CntW   = 3;
    localparam int Tmo    = 16;
    localparam int CntMax = (1 << CntW) - 1;

    // Clock / reset
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    logic            start_i = 1'b0, stop_i = 1'b0;
    logic [31:0]     start_addr_i = '0, end_addr_i = '0;
    logic            busy_o, done_o, err_o;
    logic [CntW-1:0] revoked_cnt_o;
    logic            tbre_lsu_req_o, tbre_lsu_we_o;
    logic [31:0]     tbre_lsu_addr_o, tbre_lsu_wdata_o;
    reg_cap_t        tbre_lsu_wcap_o;
    logic            lsu_tbre_req_done_i = 1'b0, lsu_tbre_resp_valid_i = 1'b0;
    logic            lsu_tbre_resp_err_i = 1'b0;
    logic [31:0]     rf_wdata_lsu_i = '0;
    reg_cap_t        rf_wcap_lsu_i = NULL_REG_CAP;
    logic            tbre_trvk_en_i = 1'b0, tbre_trvk_clrtag_i = 1'b0;

    cheri_tbre_sweep #(.TrvkTimeout(Tmo), .CntWidth(CntW)) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .start_i               (start_i),
        .stop_i                (stop_i),
        .start_addr_i          (start_addr_i),
        .end_addr_i            (end_addr_i),
        .busy_o                (busy_o),
        .done_o                (done_o),
        .err_o                 (err_o),
        .revoked_cnt_o         (revoked_cnt_o),
        .tbre_lsu_req_o        (tbre_lsu_req_o),
        .tbre_lsu_we_o         (tbre_lsu_we_o),
        .tbre_lsu_addr_o       (tbre_lsu_addr_o),
        .tbre_lsu_wdata_o      (tbre_lsu_wdata_o),
        .tbre_lsu_wcap_o       (tbre_lsu_wcap_o),
        .lsu_tbre_req_done_i   (lsu_tbre_req_done_i),
        .lsu_tbre_resp_valid_i (lsu_tbre_resp_valid_i),
        .lsu_tbre_resp_err_i   (lsu_tbre_resp_err_i),
        .rf_wdata_lsu_i        (rf_wdata_lsu_i),
        .rf_wcap_lsu_i         (rf_wcap_lsu_i),
        .tbre_trvk_en_i        (tbre_trvk_en_i),
        .tbre_trvk_clrtag_i    (tbre_trvk_clrtag_i)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        reg_cap_t    cap;
    } req_t;
    localparam int ReqW = $bits(req_t);

    typedef struct {
        logic [31:0] data;
        reg_cap_t    cap;
        logic        clr, lerr, serr, nover;
    } slot_t;

    slot_t            mem [logic [31:0]];
    logic [ReqW-1:0]  exp_q [$];
    int               checks = 0, errors = 0;
    int               n_loads = 0, n_stores = 0;
    int               grant_min = 0, grant_max = 0, resp_min = 0, resp_max = 0;
    bit               load_seen = 0, store_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic reg_cap_t rand_cap(input bit valid);
        logic [63:0] r;
        reg_cap_t    c;
        r = {$urandom, $urandom};
        c = r[$bits(reg_cap_t)-1:0];
        c.valid = valid;
        return c;
    endfunction

    function automatic slot_t get_slot(input logic [31:0] a);
        slot_t s;
        if (mem.exists(a)) return mem[a];
        s.data = a ^ 32'hA5A5_0000;
        s.cap = NULL_REG_CAP;
        s.clr = 1'b0; s.lerr = 1'b0; s.serr = 1'b0; s.nover = 1'b0;
        return s;
    endfunction

    function automatic void set_slots(input logic [31:0] base, input int n,
                                      input logic [15:0] clr, lerr, serr, inval, nover);
        slot_t s;
        mem.delete();
        for (int i = 0; i < n; i++) begin
            s.data  = $urandom;
            s.cap   = rand_cap(!inval[i]);
            s.clr   = clr[i];
            s.lerr  = lerr[i];
            s.serr  = serr[i];
            s.nover = nover[i];
            mem[base + 32'(8 * i)] = s;
        end
    endfunction

    // Reference model: every slot in [start, end) is loaded once; a slot is written back
    // only if its load succeeded, a verdict arrived, it is revoked and its cap was tagged.
    function automatic void model(input logic [31:0] s, e,
                                  output int nl, output int ns, output int cnt, output logic err);
        logic [32:0] a, lim;
        slot_t       sl;
        req_t        r;
        a = {1'b0, s & ~32'h7};
        lim = {1'b0, e & ~32'h7};
        nl = 0; ns = 0; cnt = 0; err = 1'b0;
        while (a < lim) begin
            sl = get_slot(a[31:0]);
            r = '0;
            r.addr = a[31:0];
            exp_q.push_back(r);
            nl++;
            if (sl.lerr || sl.nover) begin
                err = 1'b1;
            end else if (sl.clr && sl.cap.valid) begin
                r.we = 1'b1;
                r.data = sl.data;
                r.cap = sl.cap;
                r.cap.valid = 1'b0;
                exp_q.push_back(r);
                ns++;
                if (sl.serr) err = 1'b1;
                else if (cnt < CntMax) cnt++;
            end
            a = a + 33'd8;
            if (a[32]) break;
        end
    endfunction

    // LSU + trvk-stage responder, driven away from the active edge
    bit          outstanding = 0, cur_we = 0, late_pending = 0, trvk_clr = 0;
    logic [31:0] cur_addr = '0;
    int          grant_wait = 0, resp_wait = 0, trvk_cnt = 0;

    always @(negedge clk_i) begin
        req_t  got, e;
        slot_t sl;
        lsu_tbre_req_done_i   = 1'b0;
        lsu_tbre_resp_valid_i = 1'b0;
        lsu_tbre_resp_err_i   = 1'($urandom_range(0, 1));
        rf_wdata_lsu_i        = $urandom;
        rf_wcap_lsu_i         = rand_cap(1'($urandom_range(0, 1)));
        tbre_trvk_en_i        = 1'b0;
        tbre_trvk_clrtag_i    = 1'($urandom_range(0, 1));
        if (rst_i) begin
            outstanding = 0; trvk_cnt = 0; late_pending = 0; grant_wait = 0;
        end else begin
            if (trvk_cnt != 0) begin
                trvk_cnt--;
                if (trvk_cnt == 0) begin
                    tbre_trvk_en_i = 1'b1;
                    tbre_trvk_clrtag_i = trvk_clr;
                end
            end
            if (late_pending && tbre_lsu_req_o && !tbre_lsu_we_o) begin
                tbre_trvk_en_i = 1'b1;
                tbre_trvk_clrtag_i = 1'b1;
                late_pending = 0;
            end
            if (outstanding) begin
                if (resp_wait == 0) begin
                    lsu_tbre_resp_valid_i = 1'b1;
                    outstanding = 0;
                    sl = get_slot(cur_addr);
                    if (!cur_we) begin
                        rf_wdata_lsu_i = sl.data;
                        rf_wcap_lsu_i = sl.cap;
                        lsu_tbre_resp_err_i = sl.lerr;
                        if (sl.nover) late_pending = 1;
                        else begin
                            trvk_cnt = 3;
                            trvk_clr = sl.clr;
                        end
                    end else begin
                        lsu_tbre_resp_err_i = sl.serr;
                    end
                end else begin
                    resp_wait--;
                end
            end else if (tbre_lsu_req_o) begin
                if (grant_wait == 0) begin
                    lsu_tbre_req_done_i = 1'b1;
                    outstanding = 1;
                    cur_we = tbre_lsu_we_o;
                    cur_addr = tbre_lsu_addr_o;
                    resp_wait = $urandom_range(resp_min, resp_max);
                    grant_wait = $urandom_range(grant_min, grant_max);
                    got = '0;
                    got.we = tbre_lsu_we_o;
                    got.addr = tbre_lsu_addr_o;
                    if (got.we) begin
                        got.data = tbre_lsu_wdata_o;
                        got.cap = tbre_lsu_wcap_o;
                        n_stores++;
                        store_seen = 1;
                    end else begin
                        n_loads++;
                        load_seen = 1;
                    end
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req: got we=%0b addr=%0h, expected none",
                                 got.we, got.addr);
                    end else begin
                        e = exp_q.pop_front();
                        check("req_we_addr", {got.we, got.addr}, {e.we, e.addr});
                        if (e.we) begin
                            check("store_wdata", got.data, e.data);
                            check("store_wcap", got.cap, e.cap);
                        end
                    end
                end else begin
                    grant_wait--;
                end
            end
        end
    end

    // Starts a sweep and waits (bounded) for done_o; optionally pulses stop_i after a store grant.
    task automatic run_sweep(input logic [31:0] s, e, input bit stop_on_store, output int cycles);
        bit stop_sent;
        stop_sent = 0;
        n_loads = 0; n_stores = 0; store_seen = 0;
        @(negedge clk_i);
        check("busy_idle_before_start", busy_o, 1'b0);
        start_i = 1'b1; start_addr_i = s; end_addr_i = e;
        @(negedge clk_i);
        check("busy_rise", busy_o, 1'b1);
        cycles = 1;
        while (!done_o && cycles < 3000) begin
            // Start pulses while busy carry junk ranges and must be ignored.
            start_i = ($urandom_range(0, 7) == 0);
            start_addr_i = $urandom; end_addr_i = $urandom;
            if (stop_on_store && store_seen && !stop_sent) begin
                stop_i = 1'b1;
                stop_sent = 1;
            end else begin
                stop_i = 1'b0;
            end
            @(negedge clk_i);
            cycles++;
        end
        start_i = 1'b0; stop_i = 1'b0;
        if (!done_o) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done_o after %0d cycles, expected done", cycles);
        end else begin
            check("busy_low_in_done", busy_o, 1'b0);
            @(negedge clk_i);
            check("done_one_cycle", done_o, 1'b0);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] s, e;
        logic [15:0] clr, lerr, serr, inval, nover;
        int          loads, stores, cnt;
        logic        err;
        int          cycles;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int cyc, nl, ns, cnt, nslots;
        logic merr;
        logic [31:0] base, s, e;

        vecs[0]  = '{"empty",       32'h2001_0000, 32'h2001_0000, 16'h0,   16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 1'b0, 2};
        vecs[1]  = '{"two_clean",   32'h2001_0000, 32'h2001_0010, 16'h0,   16'h0, 16'h0, 16'h0, 16'h0, 2, 0, 0, 1'b0, -1};
        vecs[2]  = '{"revoke_one",  32'h2001_0100, 32'h2001_0108, 16'h1,   16'h0, 16'h0, 16'h0, 16'h0, 1, 1, 1, 1'b0, -1};
        vecs[3]  = '{"load_err",    32'h2001_0200, 32'h2001_0210, 16'h1,   16'h1, 16'h0, 16'h0, 16'h0, 2, 0, 0, 1'b1, -1};
        vecs[4]  = '{"untagged",    32'h2001_0300, 32'h2001_0308, 16'h1,   16'h0, 16'h0, 16'h1, 16'h0, 1, 0, 0, 1'b0, -1};
        vecs[5]  = '{"store_err",   32'h2001_0400, 32'h2001_0408, 16'h1,   16'h0, 16'h1, 16'h0, 16'h0, 1, 1, 0, 1'b1, -1};
        vecs[6]  = '{"trvk_timeout",32'h2001_0500, 32'h2001_0510, 16'h2,   16'h0, 16'h0, 16'h0, 16'h1, 2, 1, 1, 1'b1, -1};
        vecs[7]  = '{"unaligned",   32'h0000_1003, 32'h0000_100F, 16'h1,   16'h0, 16'h0, 16'h0, 16'h0, 1, 1, 1, 1'b0, -1};
        vecs[8]  = '{"top_of_mem",  32'hFFFF_FFF0, 32'hFFFF_FFF8, 16'h1,   16'h0, 16'h0, 16'h0, 16'h0, 1, 1, 1, 1'b0, -1};
        vecs[9]  = '{"reversed",    32'h0000_3000, 32'h0000_2000, 16'h1,   16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 1'b0, -1};
        vecs[10] = '{"saturate",    32'h0000_4000, 32'h0000_4048, 16'h1FF, 16'h0, 16'h0, 16'h0, 16'h0, 9, 9, 7, 1'b0, -1};
        vecs[11] = '{"mixed",       32'h0000_5000, 32'h0000_5020, 16'hB,   16'h2, 16'h0, 16'h0, 16'h0, 4, 2, 2, 1'b1, -1};

        repeat (3) @(negedge clk_i);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_req", tbre_lsu_req_o, 1'b0);
        check("rst_we", tbre_lsu_we_o, 1'b0);
        check("rst_cnt", revoked_cnt_o, 0);
        check("rst_addr", tbre_lsu_addr_o, 0);
        check("rst_wdata", tbre_lsu_wdata_o, 0);
        check("rst_wcap", tbre_lsu_wcap_o, NULL_REG_CAP);
        rst_i = 1'b0;

        // Directed vectors with immediate grant and response
        for (int i = 0; i < 12; i++) begin
            base = vecs[i].s & ~32'h7;
            nslots = (vecs[i].e & ~32'h7) > base ? int'(((vecs[i].e & ~32'h7) - base) >> 3) : 0;
            set_slots(base, nslots, vecs[i].clr, vecs[i].lerr, vecs[i].serr, vecs[i].inval, vecs[i].nover);
            exp_q.delete();
            model(vecs[i].s, vecs[i].e, nl, ns, cnt, merr);
            run_sweep(vecs[i].s, vecs[i].e, 0, cyc);
            check({vecs[i].name, "_loads"}, n_loads, vecs[i].loads);
            check({vecs[i].name, "_stores"}, n_stores, vecs[i].stores);
            check({vecs[i].name, "_err"}, err_o, vecs[i].err);
            check({vecs[i].name, "_cnt"}, revoked_cnt_o, vecs[i].cnt);
            check({vecs[i].name, "_exp_q_drained"}, exp_q.size(), 0);
            if (vecs[i].cycles >= 0) check({vecs[i].name, "_done_latency"}, cyc, vecs[i].cycles);
        end

        // Stop during STORE_WAIT: the store completes, nothing after the first slot runs
        grant_min = 0; grant_max = 0; resp_min = 3; resp_max = 3;
        set_slots(32'h0000_7000, 3, 16'h7, 16'h0, 16'h0, 16'h0, 16'h0);
        exp_q.delete();
        model(32'h0000_7000, 32'h0000_7008, nl, ns, cnt, merr);
        run_sweep(32'h0000_7000, 32'h0000_7018, 1, cyc);
        check("stop_loads", n_loads, 1);
        check("stop_stores", n_stores, 1);
        check("stop_cnt", revoked_cnt_o, 1);
        check("stop_err", err_o, 1'b0);
        check("stop_exp_q_drained", exp_q.size(), 0);

        // Asynchronous reset while waiting for a load response
        resp_min = 5; resp_max = 5;
        set_slots(32'h0000_8000, 4, 16'hF, 16'h0, 16'h0, 16'h0, 16'h0);
        exp_q.delete();
        model(32'h0000_8000, 32'h0000_8020, nl, ns, cnt, merr);
        load_seen = 0;
        @(negedge clk_i);
        start_i = 1'b1; start_addr_i = 32'h0000_8000; end_addr_i = 32'h0000_8020;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int k = 0; k < 100 && !load_seen; k++) @(negedge clk_i);
        if (!load_seen) begin
            checks++; errors++;
            $display("FAIL reset_setup: got no load grant, expected one");
        end
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        check("async_rst_busy", busy_o, 1'b0);
        check("async_rst_req", tbre_lsu_req_o, 1'b0);
        exp_q.delete();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        // Randomized sweeps against the reference model
        grant_min = 0; grant_max = 3; resp_min = 0; resp_max = 3;
        for (int t = 0; t < 10; t++) begin
            nslots = $urandom_range(1, 6);
            base = ($urandom & 32'h0FFF_FFF8) | 32'h1000_0000;
            s = base | 32'($urandom_range(0, 7));
            e = base + 32'(8 * nslots) + 32'($urandom_range(0, 7));
            set_slots(base, nslots, 16'($urandom), 16'($urandom & $urandom & $urandom),
                      16'($urandom & $urandom & $urandom), 16'($urandom & $urandom),
                      16'($urandom & $urandom & $urandom & $urandom));
            exp_q.delete();
            model(s, e, nl, ns, cnt, merr);
            run_sweep(s, e, 0, cyc);
            check("rand_loads", n_loads, nl);
            check("rand_stores", n_stores, ns);
            check("rand_err", err_o, merr);
            check("rand_cnt", revoked_cnt_o, cnt);
            check("rand_exp_q_drained", exp_q.size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
